// File: rtl/duck_ctl.sv
// Duck sprite motion controller: random launch, bouncing flight, hit/pause/fall
// and timed escape, all paced by frame_tick.
module duck_ctl #(
  parameter int SCREEN_W     = 1024,
  parameter int DUCK_W       = 64,
  parameter int DUCK_H       = 64,
  parameter int GROUND_Y     = 640,
  parameter int SPEED_X      = 4,
  parameter int SPEED_Y      = 3,
  parameter int FALL_SPEED   = 6,
  parameter int FLY_FRAMES   = 300,
  parameter int PAUSE_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        duck_visible,
  output logic        duck_dir,
  output logic        falling,
  output logic        escaped,
  output logic        fallen
);

  typedef enum logic [2:0] {IDLE, FLY, HIT_PAUSE, FALL, ESCAPE} state_t;

  localparam logic signed [12:0] X_MAX  = 13'(SCREEN_W - DUCK_W);
  localparam logic signed [12:0] Y_MAX  = 13'(GROUND_Y - DUCK_H);
  localparam logic signed [12:0] STEP_X = 13'(SPEED_X);
  localparam logic signed [12:0] STEP_Y = 13'(SPEED_Y);
  localparam logic signed [12:0] STEP_F = 13'(FALL_SPEED);
  localparam logic signed [12:0] ZERO   = 13'sd0;
  localparam logic signed [12:0] X_BASE = 13'sd200;
  localparam logic [15:0] FLY_LAST   = 16'(FLY_FRAMES - 1);
  localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_FRAMES - 1);

  state_t state_q, state_d;
  logic signed [12:0] x_q, x_d, y_q, y_d;
  logic signed [12:0] next_x, next_y, fall_y, rise_y;
  logic dir_d, up_q, up_d;
  logic [15:0] frame_q, frame_d, pause_q, pause_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic lfsr_fb;
  logic escaped_d, fallen_d;

  // Right-shifting Fibonacci form of taps 16,14,13,11
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

  assign xpos = x_q[11:0];
  assign ypos = y_q[11:0];

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = duck_dir;
    up_d      = up_q;
    frame_d   = frame_q;
    pause_d   = pause_q;
    escaped_d = 1'b0;
    fallen_d  = 1'b0;
    next_x    = duck_dir ? (x_q + STEP_X) : (x_q - STEP_X);
    next_y    = up_q ? (y_q - STEP_Y) : (y_q + STEP_Y);
    fall_y    = y_q + STEP_F;
    rise_y    = y_q - STEP_Y;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = $signed({4'b0000, lfsr_q[8:0]}) + X_BASE;
          y_d     = Y_MAX;
          dir_d   = lfsr_q[9];
          up_d    = 1'b1;
          frame_d = '0;
          pause_d = '0;
          state_d = FLY;
        end
      end
      FLY: begin
        // A hit wins over a simultaneous tick, so the duck freezes where it was shot
        if (hit) begin
          frame_d = '0;
          pause_d = '0;
          state_d = HIT_PAUSE;
        end else if (frame_tick) begin
          if (frame_q == FLY_LAST) begin
            frame_d = '0;
            state_d = ESCAPE;
          end else begin
            frame_d = frame_q + 16'd1;
            if (next_x < ZERO) begin
              x_d   = ZERO;
              dir_d = ~duck_dir;
            end else if (next_x > X_MAX) begin
              x_d   = X_MAX;
              dir_d = ~duck_dir;
            end else begin
              x_d = next_x;
            end
            if (next_y < ZERO) begin
              y_d  = ZERO;
              up_d = ~up_q;
            end else if (next_y > Y_MAX) begin
              y_d  = Y_MAX;
              up_d = ~up_q;
            end else begin
              y_d = next_y;
            end
          end
        end
      end
      HIT_PAUSE: begin
        if (frame_tick) begin
          if (pause_q == PAUSE_LAST) begin
            pause_d = '0;
            state_d = FALL;
          end else begin
            pause_d = pause_q + 16'd1;
          end
        end
      end
      FALL: begin
        if (frame_tick) begin
          if (fall_y >= Y_MAX) begin
            y_d      = Y_MAX;
            fallen_d = 1'b1;
            state_d  = IDLE;
          end else begin
            y_d = fall_y;
          end
        end
      end
      ESCAPE: begin
        if (frame_tick) begin
          if (rise_y < ZERO) begin
            y_d       = ZERO;
            escaped_d = 1'b1;
            state_d   = IDLE;
          end else begin
            y_d = rise_y;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags come from the next state so every output is a flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      duck_dir     <= 1'b0;
      up_q         <= 1'b0;
      frame_q      <= '0;
      pause_q      <= '0;
      lfsr_q       <= 16'hACE1;
      duck_visible <= 1'b0;
      falling      <= 1'b0;
      escaped      <= 1'b0;
      fallen       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      duck_dir     <= dir_d;
      up_q         <= up_d;
      frame_q      <= frame_d;
      pause_q      <= pause_d;
      lfsr_q       <= lfsr_d;
      duck_visible <= (state_d != IDLE);
      falling      <= (state_d == FALL);
      escaped      <= escaped_d;
      fallen       <= fallen_d;
    end
  end

endmodule

// File: tb/tb_duck_ctl.sv
// Bench for duck_ctl: directed scenarios plus random traffic, all checked
// every cycle against an abstract duck model.
module tb_duck_ctl;

  localparam int X_MAX = 960;
  localparam int Y_MAX = 576;
  localparam int FLY_FRAMES = 300;
  localparam int PAUSE_FRAMES = 30;
  localparam int S_IDLE = 0, S_FLY = 1, S_PAUSE = 2, S_FALL = 3, S_ESC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0, start = 1'b0, hit = 1'b0;
  logic [11:0] xpos, ypos;
  logic duck_visible, duck_dir, falling, escaped, fallen;

  int compared = 0;
  int mismatched = 0;
  bit check_en = 0;

  int m_state, mx, my, mcnt, mpause;
  bit mdir, mup, mesc, mfal;
  int unsigned mlfsr;

  always #5 clk = ~clk;

  duck_ctl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .hit(hit),
    .xpos(xpos), .ypos(ypos), .duck_visible(duck_visible), .duck_dir(duck_dir),
    .falling(falling), .escaped(escaped), .fallen(fallen)
  );

  function automatic void checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int unsigned lfsr_next(input int unsigned v);
    int unsigned fb;
    fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return ((v >> 1) | (fb << 15)) & 32'hFFFF;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; mx = 0; my = 0; mdir = 0; mup = 0;
    mcnt = 0; mpause = 0; mlfsr = 32'hACE1; mesc = 0; mfal = 0;
  endtask

  // One axis of flight: move, and if past a wall, sit on the wall and reverse
  task automatic bounce(input int pos, input int step, input int hi, input bit dir,
                        output int npos, output bit ndir);
    int t;
    t = dir ? pos + step : pos - step;
    ndir = dir;
    if (t < 0) begin npos = 0; ndir = !dir; end
    else if (t > hi) begin npos = hi; ndir = !dir; end
    else npos = t;
  endtask

  task automatic model_edge(input bit s, input bit h, input bit f);
    int unsigned cur;
    int t;
    cur = mlfsr; mesc = 0; mfal = 0;
    case (m_state)
      S_IDLE: if (s) begin
        mx = int'(cur % 512) + 200; my = Y_MAX; mdir = ((cur >> 9) & 1) != 0;
        mup = 1; mcnt = 0; m_state = S_FLY;
      end
      S_FLY: if (h) begin
        m_state = S_PAUSE; mpause = 0; mcnt = 0;
      end else if (f) begin
        mcnt++;
        if (mcnt == FLY_FRAMES) m_state = S_ESC;
        else begin
          bounce(mx, 4, X_MAX, mdir, mx, mdir);
          bounce(my, 3, Y_MAX, !mup, my, mup);
          mup = !mup;
        end
      end
      S_PAUSE: if (f) begin
        mpause++;
        if (mpause == PAUSE_FRAMES) m_state = S_FALL;
      end
      S_FALL: if (f) begin
        t = my + 6;
        if (t >= Y_MAX) begin my = Y_MAX; mfal = 1; m_state = S_IDLE; end
        else my = t;
      end
      S_ESC: if (f) begin
        t = my - 3;
        if (t < 0) begin my = 0; mesc = 1; m_state = S_IDLE; end
        else my = t;
      end
      default: m_state = S_IDLE;
    endcase
    mlfsr = lfsr_next(cur);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("xpos", int'(xpos), mx);
      checkOutput("ypos", int'(ypos), my);
      checkOutput("duck_dir", int'(duck_dir), int'(mdir));
      checkOutput("duck_visible", int'(duck_visible), int'(m_state != S_IDLE));
      checkOutput("falling", int'(falling), int'(m_state == S_FALL));
      checkOutput("escaped", int'(escaped), int'(mesc));
      checkOutput("fallen", int'(fallen), int'(mfal));
    end
  end

  // Inputs change 1ns after a rising edge and are held for the whole next cycle
  task automatic applyStimulus(input bit s, input bit h, input bit f);
    start = s; hit = h; frame_tick = f;
    @(posedge clk);
    if (rst) model_edge(s, h, f);
    #1;
    start = 0; hit = 0; frame_tick = 0;
  endtask

  task automatic doReset();
    rst = 0;
    model_reset();
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    rst = 1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1);
  endtask

  initial begin
    int px, py, n;
    bit seen;

    #2 rst = 0;
    model_reset();
    check_en = 1;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("reset_ypos", int'(ypos), 0);
    checkOutput("reset_visible", int'(duck_visible), 0);
    rst = 1;

    // Launch after five idle cycles
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("start_xrange", int'(xpos >= 200 && xpos <= 711), 1);
    checkOutput("start_ypos", int'(ypos), 576);
    checkOutput("start_visible", int'(duck_visible), 1);

    // Hit together with a tick freezes the duck
    ticks(5);
    checkOutput("fly5_ypos", int'(ypos), 561);
    px = int'(xpos); py = int'(ypos);
    applyStimulus(0, 1, 1);
    checkOutput("hit_tick_x", int'(xpos), px);
    checkOutput("hit_tick_y", int'(ypos), py);
    ticks(29);
    checkOutput("pause29_falling", int'(falling), 0);
    ticks(1);
    checkOutput("pause30_falling", int'(falling), 1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      applyStimulus(0, 0, 1);
      seen = fallen;
    end
    checkOutput("fallen_seen", int'(seen), 1);
    checkOutput("landed_ypos", int'(ypos), 576);
    applyStimulus(0, 0, 0);
    checkOutput("fallen_single", int'(fallen), 0);
    checkOutput("landed_idle", int'(duck_visible), 0);

    applyStimulus(0, 1, 1);
    checkOutput("idle_hit_ignored", int'(duck_visible), 0);

    // Wait for a launch that reaches x = 958 heading right
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if ((((mlfsr % 512) + 200) % 4 == 2) && (((mlfsr >> 9) & 1) == 1)) begin
        applyStimulus(1, 0, 0);
        seen = 1;
      end else applyStimulus(0, 0, 0);
    end
    checkOutput("bounce_launch_found", int'(seen), 1);
    applyStimulus(0, 0, 1);
    px = int'(xpos);
    applyStimulus(1, 0, 0);
    checkOutput("fly_start_ignored_x", int'(xpos), px);
    checkOutput("fly_start_ignored_vis", int'(duck_visible), 1);
    n = 0;
    while (mx != 958 && n < 300) begin
      applyStimulus(0, 0, 1);
      n++;
    end
    checkOutput("bounce_pre_x", int'(xpos), 958);
    applyStimulus(0, 0, 1);
    checkOutput("bounce_edge_x", int'(xpos), 960);
    checkOutput("bounce_edge_dir", int'(duck_dir), 0);
    applyStimulus(0, 0, 1);
    checkOutput("bounce_back_x", int'(xpos), 956);

    // Let the flight time out and climb off the top
    seen = 0;
    for (int i = 0; i < 800 && !seen; i++) begin
      applyStimulus(0, 0, 1);
      seen = escaped;
      if (!seen) applyStimulus(0, 0, 0);
    end
    checkOutput("escaped_seen", int'(seen), 1);
    checkOutput("escaped_ypos", int'(ypos), 0);
    applyStimulus(0, 0, 0);
    checkOutput("escaped_single", int'(escaped), 0);
    checkOutput("escaped_idle", int'(duck_visible), 0);

    // Reset in the middle of a fall
    applyStimulus(1, 0, 0);
    ticks(10);
    applyStimulus(0, 1, 0);
    ticks(PAUSE_FRAMES + 1);
    checkOutput("fall_before_reset", int'(falling), 1);
    rst = 0;
    #1;
    checkOutput("async_xpos", int'(xpos), 0);
    checkOutput("async_ypos", int'(ypos), 0);
    checkOutput("async_vis_dir", int'({duck_visible, duck_dir}), 0);
    checkOutput("async_flags", int'({falling, escaped, fallen}), 0);
    model_reset();
    applyStimulus(0, 0, 1);
    rst = 1;
    applyStimulus(0, 0, 1);
    checkOutput("post_reset_idle", int'(duck_visible), 0);

    // Random traffic
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(4999) == 0) doReset();
      else applyStimulus($urandom_range(49) == 0, $urandom_range(599) == 0,
                         $urandom_range(2) == 0);
    end

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
